// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel reconstruction slice: FSM state
// encoding, default frame geometry and the RGB565 colour-bar palette.
package cam_pkg;

  typedef enum logic [1:0] {
    S_SYNC,  // waiting for the first frame start
    S_HI,    // next href byte is the pixel's high byte
    S_LO     // next href byte is the pixel's low byte
  } state_t;

  localparam int H_PIXELS_DEFAULT = 320;
  localparam int V_LINES_DEFAULT  = 240;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  // Colour of bar idx, left (white) to right (black).
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// Registers a 1-bit camera sync signal and flags its rising and falling
// edges on the cycle the new level is first sampled.
module cam_edge_detect (
  input  logic cam_clk_in,
  input  logic rst_n_in,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // Previous-cycle copy of the input; resets low so a signal that is
  // already low out of reset never produces a spurious falling edge.
  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    // NOTE: non-blocking (<=) in clocked blocks so every flop samples the
    // pre-edge value of its inputs regardless of statement order.
    if (!rst_n_in) sig_q <= 1'b0;
    else           sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/pixel_reconstruct.sv
// Reassembles RGB565 pixels from a DVP-style camera byte stream (two bytes
// per pixel, high byte first), tracks line/column position, suppresses
// out-of-range pixels and flags malformed lines and frames.
// Optional feature: define PIXEL_TEST_PATTERN_EN to add test_pattern_in,
// which replaces pixel data with eight vertical colour bars.
module pixel_reconstruct
  import cam_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEFAULT,
  parameter int V_LINES  = V_LINES_DEFAULT
) (
  input  logic        cam_clk_in,
  input  logic        rst_n_in,
  input  logic        camera_vs_in,
  input  logic        camera_hs_in,
  input  logic [7:0]  camera_data_in,
`ifdef PIXEL_TEST_PATTERN_EN
  input  logic        test_pattern_in,
`endif
  output logic        valid_pixel_out,
  output logic [15:0] pixel_out,
  output logic        frame_done_out,
  output logic [8:0]  hcount_out,
  output logic [7:0]  vcount_out,
  output logic        line_err_out,
  output logic        frame_err_out
);

  localparam logic [8:0] H_LIM = 9'(H_PIXELS);
  localparam logic [7:0] V_LIM = 8'(V_LINES);

  state_t     state;
  logic [7:0] hi_byte;
  logic [8:0] hcount;
  logic [7:0] vcount;
  logic       vs_rise, vs_fall, hs_rise, hs_fall;
  logic [15:0] next_pixel;

  cam_edge_detect u_vs_edge (
    .cam_clk_in (cam_clk_in),
    .rst_n_in   (rst_n_in),
    .sig        (camera_vs_in),
    .rise       (vs_rise),
    .fall       (vs_fall)
  );

  cam_edge_detect u_hs_edge (
    .cam_clk_in (cam_clk_in),
    .rst_n_in   (rst_n_in),
    .sig        (camera_hs_in),
    .rise       (hs_rise),
    .fall       (hs_fall)
  );

`ifdef PIXEL_TEST_PATTERN_EN
  localparam logic [8:0] BAR_LAST = 9'(H_PIXELS / 8 - 1);
  logic [8:0] bar_col;
  logic [2:0] bar_idx;
  assign next_pixel = test_pattern_in ? bar_color(bar_idx) : {hi_byte, camera_data_in};

  // Bar position follows the column counter: restart at each line and
  // frame start, advance once per assembled pixel, hold on the last bar.
  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bar_col <= '0;
      bar_idx <= '0;
    end else if (vs_fall || hs_fall) begin
      bar_col <= '0;
      bar_idx <= '0;
    end else if (state == S_LO && !hs_rise && camera_hs_in && !camera_vs_in) begin
      if (bar_col == BAR_LAST) begin
        bar_col <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_col <= bar_col + 9'd1;
      end
    end
  end
`else
  assign next_pixel = {hi_byte, camera_data_in};
`endif

  // Byte-pairing FSM with position counters and registered outputs; vsync
  // edges outrank href edges, which outrank byte capture.
  always_ff @(posedge cam_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= S_SYNC;
      hi_byte         <= '0;
      hcount          <= '0;
      vcount          <= '0;
      valid_pixel_out <= 1'b0;
      pixel_out       <= '0;
      frame_done_out  <= 1'b0;
      hcount_out      <= '0;
      vcount_out      <= '0;
      line_err_out    <= 1'b0;
      frame_err_out   <= 1'b0;
    end else begin
      valid_pixel_out <= 1'b0;
      frame_done_out  <= 1'b0;
      if (vs_fall) begin
        // Frame start: also the only exit from S_SYNC.
        state         <= S_HI;
        hcount        <= '0;
        vcount        <= '0;
        line_err_out  <= 1'b0;
        frame_err_out <= 1'b0;
      end else if (state == S_SYNC) begin
        state <= S_SYNC;
      end else if (vs_rise) begin
        frame_done_out <= 1'b1;
        if (vcount != V_LIM) frame_err_out <= 1'b1;
        state <= S_HI;
      end else if (hs_fall) begin
        // Ending a line on a dangling high byte is an odd-byte error too.
        if (hcount != H_LIM || state == S_LO) line_err_out <= 1'b1;
        hcount <= '0;
        if (vcount != 8'hFF) vcount <= vcount + 8'd1;
        state <= S_HI;
      end else if (camera_hs_in && !camera_vs_in) begin
        // The first byte of a line is always a high byte.
        if (state == S_HI || hs_rise) begin
          hi_byte <= camera_data_in;
          state   <= S_LO;
        end else begin
          if (hcount < H_LIM && vcount < V_LIM) begin
            valid_pixel_out <= 1'b1;
            pixel_out       <= next_pixel;
            hcount_out      <= hcount;
            vcount_out      <= vcount;
          end
          if (hcount != 9'h1FF) hcount <= hcount + 9'd1;
          state <= S_HI;
        end
      end else if (state == S_LO && !camera_hs_in) begin
        line_err_out <= 1'b1;
        state        <= S_HI;
      end
    end
  end

endmodule
